// File: rtl/eu_pkg.sv
// Shared types for the EU dispatcher: command opcodes, sticky error codes,
// FSM state encoding and the one-hot strobe helper.
package eu_pkg;

  localparam int UNIT_W   = 5;
  localparam int STROBE_W = 32;

  typedef enum logic [1:0] {
    OP_NOP        = 2'b00,
    OP_FETCH      = 2'b01,
    OP_EXEC       = 2'b10,
    OP_FETCH_EXEC = 2'b11
  } cmd_op_e;

  typedef enum logic [1:0] {
    ERR_NONE      = 2'b00,
    ERR_BAD_UNIT  = 2'b01,
    ERR_FETCH_TMO = 2'b10,
    ERR_EXEC_TMO  = 2'b11
  } err_code_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_F_ISSUE,
    S_F_GUARD,
    S_F_WAIT,
    S_X_ISSUE,
    S_X_GUARD,
    S_X_WAIT
  } state_e;

  typedef struct packed {
    cmd_op_e           op;
    logic [UNIT_W-1:0] unit;
  } cmd_t;

  function automatic logic [STROBE_W-1:0] unit_onehot(input logic [UNIT_W-1:0] unit);
    logic [STROBE_W-1:0] v;
    v       = '0;
    v[unit] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/eu_timeout_cnt.sv
// Wait-phase cycle counter: cleared outside a wait phase, counts while enabled,
// flags expiry on the LIMIT-th enabled cycle.
module eu_timeout_cnt #(
  parameter int unsigned LIMIT = 65535
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  // A zero limit behaves like one: expire on the first wait cycle.
  localparam logic [31:0] LAST = (LIMIT == 0) ? 32'd0 : 32'(LIMIT - 1);

  logic [31:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  count <= '0;
    else if (clear)              count <= '0;
    else if (enable && !expired) count <= count + 32'd1;
  end

  assign expired = enable && (count >= LAST);

endmodule

// File: rtl/eu_dispatch.sv
// EU command dispatcher: accepts FETCH / EXEC / FETCH_EXEC commands, pulses the
// one-hot strobes, waits for the done levels with timeout, reports sticky errors.
module eu_dispatch
  import eu_pkg::*;
#(
  parameter int          NUM_UNITS      = 28,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_op,
  input  logic [UNIT_W-1:0]    cmd_unit,
  input  logic [31:0]          cmd_addr,
  output logic [UNIT_W-1:0]    sdram_read_sel,
  output logic [STROBE_W-1:0]  eu_fetch,
  output logic [STROBE_W-1:0]  eu_exec,
  output logic [31:0]          eu_fetch_addr,
  input  logic                 fetch_done,
  input  logic [NUM_UNITS-1:0] exec_done,
  output logic                 busy,
  output logic                 cmd_done,
  output logic [1:0]           err_code,
  input  logic                 err_clr
);

  state_e              state;
  cmd_t                cmd_q;
  err_code_e           err_evt;
  logic                accept;
  logic                unit_ok;
  logic                waiting;
  logic                wait_hit;
  logic                tmo;
  logic                finish;
  logic [STROBE_W-1:0] exec_vec;
  cmd_op_e             op_in;

  assign op_in    = cmd_op_e'(cmd_op);
  assign accept   = cmd_valid & cmd_ready;
  assign unit_ok  = 32'(cmd_unit) < 32'(NUM_UNITS);
  assign exec_vec = 32'(exec_done);
  assign waiting  = (state == S_F_WAIT) || (state == S_X_WAIT);
  assign wait_hit = (state == S_F_WAIT) ? fetch_done : exec_vec[cmd_q.unit];

  eu_timeout_cnt #(.LIMIT(TIMEOUT_CYCLES)) u_tmo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (!waiting),
    .enable  (waiting),
    .expired (tmo)
  );

  // Wait-phase exit and the error event raised this cycle (done beats expiry).
  always_comb begin
    err_evt = ERR_NONE;
    finish  = 1'b0;
    unique case (state)
      S_IDLE:   if (accept && !unit_ok) err_evt = ERR_BAD_UNIT;
      S_F_WAIT: begin
        if (fetch_done) finish = (cmd_q.op != OP_FETCH_EXEC);
        else if (tmo) begin
          finish  = 1'b1;
          err_evt = ERR_FETCH_TMO;
        end
      end
      S_X_WAIT: begin
        if (wait_hit) finish = 1'b1;
        else if (tmo) begin
          finish  = 1'b1;
          err_evt = ERR_EXEC_TMO;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      cmd_q          <= '{op: OP_NOP, unit: '0};
      cmd_ready      <= 1'b0;
      busy           <= 1'b0;
      cmd_done       <= 1'b0;
      eu_fetch       <= '0;
      eu_exec        <= '0;
      sdram_read_sel <= '0;
      eu_fetch_addr  <= '0;
    end else begin
      cmd_done <= 1'b0;
      eu_fetch <= '0;
      eu_exec  <= '0;
      if (finish) begin
        state     <= S_IDLE;
        busy      <= 1'b0;
        cmd_ready <= 1'b1;
        cmd_done  <= 1'b1;
      end else begin
        unique case (state)
          S_IDLE: begin
            cmd_ready <= 1'b1;
            if (accept) begin
              cmd_q          <= '{op: op_in, unit: cmd_unit};
              sdram_read_sel <= cmd_unit;
              eu_fetch_addr  <= cmd_addr;
              // Bad unit and NOP complete in place without touching any strobe.
              if (!unit_ok || op_in == OP_NOP) begin
                cmd_done <= 1'b1;
              end else begin
                cmd_ready <= 1'b0;
                busy      <= 1'b1;
                if (op_in == OP_EXEC) begin
                  state   <= S_X_ISSUE;
                  eu_exec <= unit_onehot(cmd_unit);
                end else begin
                  state    <= S_F_ISSUE;
                  eu_fetch <= unit_onehot(cmd_unit);
                end
              end
            end
          end
          S_F_ISSUE: state <= S_F_GUARD;
          S_F_GUARD: state <= S_F_WAIT;
          S_F_WAIT: begin
            // Only reached without finish when chaining into the exec phase.
            if (fetch_done) begin
              state   <= S_X_ISSUE;
              eu_exec <= unit_onehot(cmd_q.unit);
            end
          end
          S_X_ISSUE: state <= S_X_GUARD;
          S_X_GUARD: state <= S_X_WAIT;
          S_X_WAIT:  ;
          default:   state <= S_IDLE;
        endcase
      end
    end
  end

  // Sticky first error; a new error in the clearing cycle replaces the old one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      err_code <= ERR_NONE;
    else if (err_evt != ERR_NONE && (err_code == ERR_NONE || err_clr))
      err_code <= err_evt;
    else if (err_clr)
      err_code <= ERR_NONE;
  end

endmodule

// File: tb/tb_eu_dispatch.sv
// Bench for eu_dispatch: vector table of commands with done timing, a scoreboard
// of expected completions, and hand sequences for reset and back-to-back issue.
module tb_eu_dispatch;

  localparam int NU  = 28;
  localparam int TMO = 16;
  localparam int NV  = 17;

  localparam logic [1:0] NOP = 2'b00, FE = 2'b01, EX = 2'b10, FX = 2'b11;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [4:0]    cmd_unit;
  logic [31:0]   cmd_addr;
  logic [4:0]    sdram_read_sel;
  logic [31:0]   eu_fetch;
  logic [31:0]   eu_exec;
  logic [31:0]   eu_fetch_addr;
  logic          fetch_done;
  logic [NU-1:0] exec_done;
  logic          busy;
  logic          cmd_done;
  logic [1:0]    err_code;
  logic          err_clr;

  eu_dispatch #(.NUM_UNITS(NU), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_unit(cmd_unit), .cmd_addr(cmd_addr),
    .sdram_read_sel(sdram_read_sel), .eu_fetch(eu_fetch), .eu_exec(eu_exec),
    .eu_fetch_addr(eu_fetch_addr), .fetch_done(fetch_done), .exec_done(exec_done),
    .busy(busy), .cmd_done(cmd_done), .err_code(err_code), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  // fdone/xdone: cycle (from accept) at which the done level rises, -1 never.
  // lat: accept cycle to cmd_done cycle; f_at/x_at: cycle of the strobe, -1 none.
  typedef struct {
    logic [1:0]  op;
    logic [4:0]  unit;
    logic [31:0] addr;
    bit          pre_clr;
    int          fdone;
    int          xdone;
    bit          noise;
    int          clr_at;
    int          lat;
    logic [1:0]  err;
    logic [31:0] sv;
    int          f_at;
    int          x_at;
  } vec_t;

  typedef struct {
    int          acc;
    int          lat;
    logic [1:0]  err;
    logic [4:0]  sel;
    logic [31:0] addr;
  } exp_t;

  vec_t vt [NV];
  exp_t sb [$];
  exp_t mon_it;
  int   ncyc   = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) ncyc <= ncyc + 1;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, ncyc);
    end
  endfunction

  function automatic void fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired (cycle %0d)", name, ncyc);
  endfunction

  // Scoreboard consumer: every cmd_done pops one expected completion.
  always @(negedge clk) begin
    if (rst_n && cmd_done) begin
      if (sb.size() == 0) fail("unexpected_cmd_done");
      else begin
        mon_it = sb.pop_front();
        chk("latency", 32'(ncyc - mon_it.acc), 32'(mon_it.lat));
        chk("err_code", 32'(err_code), 32'(mon_it.err));
        chk("sdram_read_sel", 32'(sdram_read_sel), 32'(mon_it.sel));
        chk("eu_fetch_addr", eu_fetch_addr, mon_it.addr);
        chk("ready_at_done", 32'(cmd_ready), 32'd1);
      end
    end
  end

  task automatic issue(input logic [1:0] op, input logic [4:0] unit,
                       input logic [31:0] addr, output int a0);
    int n = 0;
    cmd_op = op; cmd_unit = unit; cmd_addr = addr; cmd_valid = 1'b1;
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (cmd_ready) a0 = ncyc;
    else begin
      fail("accept_wait");
      a0 = -1;
    end
  endtask

  task automatic run_vec(input vec_t v);
    int            a0;
    int            k;
    bit            got;
    logic [NU-1:0] xv;
    if (v.pre_clr) begin
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      chk("err_clr", 32'(err_code), 32'd0);
    end
    issue(v.op, v.unit, v.addr, a0);
    if (a0 >= 0) begin
      sb.push_back('{a0, v.lat, v.err, v.unit, v.addr});
      k   = 0;
      got = 1'b0;
      while (!got && k <= 40) begin
        if (k > 0) cmd_valid = 1'b0;
        fetch_done = (v.fdone >= 0 && k >= v.fdone);
        xv = v.noise ? '1 : '0;
        if (v.unit < NU) xv[v.unit] = (v.xdone >= 0 && k >= v.xdone);
        exec_done = xv;
        err_clr   = (k == v.clr_at);
        if (k > 0) begin
          chk("eu_fetch", eu_fetch, (k == v.f_at) ? v.sv : 32'd0);
          chk("eu_exec", eu_exec, (k == v.x_at) ? v.sv : 32'd0);
          if (k < v.lat) begin
            chk("busy", 32'(busy), 32'd1);
            chk("cmd_ready_busy", 32'(cmd_ready), 32'd0);
          end
          if (cmd_done) begin
            chk("busy_end", 32'(busy), 32'd0);
            got = 1'b1;
          end
        end
        if (!got) begin
          @(negedge clk);
          k++;
        end
      end
      if (!got) begin
        fail("cmd_done_wait");
        sb.delete();
      end
    end
    cmd_valid = 1'b0; fetch_done = 1'b0; exec_done = '0; err_clr = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int a0, a1, n;

    //        op   unit   addr          clr fd  xd  nz clr lat err    sv            f_at x_at
    vt[0]  = '{FE,  5'd5,  32'h0000_1000, 1,  4, -1, 0, -1, 5,  2'b00, 32'h0000_0020, 1, -1};
    vt[1]  = '{FE,  5'd0,  32'h0000_0000, 1,  0, -1, 0, -1, 4,  2'b00, 32'h0000_0001, 1, -1};
    vt[2]  = '{FX,  5'd9,  32'h0000_2000, 1,  0,  0, 0, -1, 7,  2'b00, 32'h0000_0200, 1,  4};
    vt[3]  = '{FX,  5'd9,  32'h0000_2004, 1,  6, 10, 0, -1, 11, 2'b00, 32'h0000_0200, 1,  7};
    vt[4]  = '{EX,  5'd27, 32'h0000_0000, 1, -1,  0, 0, -1, 4,  2'b00, 32'h0800_0000, -1, 1};
    vt[5]  = '{EX,  5'd6,  32'h0000_0600, 1, -1,  8, 1, -1, 9,  2'b00, 32'h0000_0040, -1, 1};
    vt[6]  = '{NOP, 5'd2,  32'h0000_0055, 1, -1, -1, 0, -1, 1,  2'b00, 32'h0000_0000, -1, -1};
    vt[7]  = '{FE,  5'd30, 32'h0000_0066, 1, -1, -1, 0, -1, 1,  2'b01, 32'h0000_0000, -1, -1};
    vt[8]  = '{EX,  5'd28, 32'h0000_0077, 1, -1, -1, 0, -1, 1,  2'b01, 32'h0000_0000, -1, -1};
    vt[9]  = '{EX,  5'd4,  32'h0000_0400, 1, -1, 18, 0, -1, 19, 2'b00, 32'h0000_0010, -1, 1};
    vt[10] = '{EX,  5'd4,  32'h0000_0404, 1, -1, 19, 0, -1, 19, 2'b11, 32'h0000_0010, -1, 1};
    vt[11] = '{FE,  5'd7,  32'h0000_0700, 1, -1, -1, 0, -1, 19, 2'b10, 32'h0000_0080, 1, -1};
    vt[12] = '{FX,  5'd1,  32'h0000_0100, 1,  2, -1, 0, -1, 22, 2'b11, 32'h0000_0002, 1,  4};
    vt[13] = '{FE,  5'd31, 32'h0000_3100, 1, -1, -1, 0, -1, 1,  2'b01, 32'h0000_0000, -1, -1};
    vt[14] = '{FE,  5'd7,  32'h0000_0701, 0, -1, -1, 0, -1, 19, 2'b01, 32'h0000_0080, 1, -1};
    vt[15] = '{EX,  5'd12, 32'h0000_1200, 0, -1, -1, 0, 18, 19, 2'b11, 32'h0000_1000, -1, 1};
    vt[16] = '{NOP, 5'd0,  32'h0000_0000, 1, -1, -1, 0, -1, 1,  2'b00, 32'h0000_0000, -1, -1};

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_unit = '0; cmd_addr = '0;
    fetch_done = 1'b0; exec_done = '0; err_clr = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cmd_done", 32'(cmd_done), 32'd0);
    chk("rst_eu_fetch", eu_fetch, 32'd0);
    chk("rst_eu_exec", eu_exec, 32'd0);
    chk("rst_sel", 32'(sdram_read_sel), 32'd0);
    chk("rst_addr", eu_fetch_addr, 32'd0);
    chk("rst_err", 32'(err_code), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", 32'(cmd_ready), 32'd1);

    // Reset while the fetch strobe is up: it must fall without a clock edge.
    issue(FE, 5'd3, 32'h0000_0300, a0);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("strobe_before_rst", eu_fetch, 32'h0000_0008);
    rst_n = 1'b0;
    #1;
    chk("async_rst_fetch", eu_fetch, 32'd0);
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_ready", 32'(cmd_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset in F_WAIT abandons the command silently.
    issue(FE, 5'd5, 32'hABCD_0000, a0);
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("fwait_busy", 32'(busy), 32'd1);
    chk("fwait_sel", 32'(sdram_read_sel), 32'd5);
    chk("fwait_addr", eu_fetch_addr, 32'hABCD_0000);
    rst_n = 1'b0;
    #1;
    chk("fwait_rst_sel", 32'(sdram_read_sel), 32'd0);
    chk("fwait_rst_addr", eu_fetch_addr, 32'd0);
    chk("fwait_rst_busy", 32'(busy), 32'd0);
    chk("fwait_rst_err", 32'(err_code), 32'd0);
    repeat (2) begin
      @(negedge clk);
      chk("fwait_rst_no_done", 32'(cmd_done), 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < NV; i++) run_vec(vt[i]);

    // Back-to-back: second command held valid is taken on the first's done cycle.
    issue(FE, 5'd2, 32'h0000_0022, a0);
    sb.push_back('{a0, 4, 2'b00, 5'd2, 32'h0000_0022});
    fetch_done = 1'b1;
    exec_done  = '0;
    exec_done[3] = 1'b1;
    @(negedge clk);
    cmd_op = EX; cmd_unit = 5'd3; cmd_addr = 32'h0000_0033;
    n = 0;
    while (!cmd_ready && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) fail("b2b_accept");
    else begin
      a1 = ncyc;
      chk("b2b_gap", 32'(a1 - a0), 32'd4);
      sb.push_back('{a1, 4, 2'b00, 5'd3, 32'h0000_0033});
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    n = 0;
    while (sb.size() != 0 && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      fail("b2b_done_wait");
      sb.delete();
    end
    fetch_done = 1'b0; exec_done = '0;
    repeat (2) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    chk("idle_ready", 32'(cmd_ready), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
